// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller.
// Holds the BCD digit format, the enable/disable levels and the FSM state
// encoding used by countdown_ctrl and its testbench.
package countdown_ctrl_pkg;

  localparam int BCD_BIT_WIDTH = 4;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO = '0;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  localparam int STATE_BIT_WIDTH = 2;

  typedef enum logic [STATE_BIT_WIDTH-1:0] {
    STATE_IDLE  = 2'd0,
    STATE_RUN   = 2'd1,
    STATE_PAUSE = 2'd2,
    STATE_DONE  = 2'd3
  } state_t;

  // True when both counter digits read 00.
  function automatic logic is_zero(input logic [BCD_BIT_WIDTH-1:0] tens,
                                   input logic [BCD_BIT_WIDTH-1:0] units);
    return (tens == BCD_ZERO) && (units == BCD_ZERO);
  endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler for the countdown decrement strobe.
// Counts 0..TICK_DIV-1 while en_i is high and wraps to 0; clr_i forces the
// count back to 0 and takes priority over counting.
// Ports:
//   clk     in   global clock
//   rst_n   in   asynchronous active-low reset
//   clr_i   in   synchronous clear
//   en_i    in   count enable
//   wrap_o  out  high for the cycle in which the count sits at TICK_DIV-1
//                while enabled (the next edge wraps it to 0)
module tick_gen #(
  parameter int TICK_DIV = 100_000_000,
  parameter int TICK_W   = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap_o  = en_i & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Sequencing controller for the 2-digit BCD 30 s countdown counter.
// Converts the debounced start/stop and clear buttons into an
// IDLE/RUN/PAUSE/DONE FSM, generates the 1 Hz decrement strobe from the
// prescaler, detects 00 on the counter digits and requests reloads.
// Ports:
//   clk       in   global clock
//   rst_n     in   asynchronous active-low reset
//   ss_btn    in   start/stop button level, active-high
//   clr_btn   in   clear button level, active-high
//   digit1    in   counter tens digit (BCD)
//   digit0    in   counter units digit (BCD)
//   cnt_en    out  1-cycle decrement strobe to the counter
//   cnt_load  out  1-cycle reload request (counter -> 30)
//   running   out  high in RUN
//   paused    out  high in PAUSE
//   alarm     out  high in DONE
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int TICK_W   = 27
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ss_btn,
  input  logic                     clr_btn,
  input  logic [BCD_BIT_WIDTH-1:0] digit1,
  input  logic [BCD_BIT_WIDTH-1:0] digit0,
  output logic                     cnt_en,
  output logic                     cnt_load,
  output logic                     running,
  output logic                     paused,
  output logic                     alarm
);

  state_t state_q, state_d;
  logic   ss_q, clr_q;
  logic   ss_press, clr_press;
  logic   zero;
  logic   tick_en, tick_clr, tick_wrap;

  // Button history and state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_IDLE;
      ss_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= ss_btn;
      clr_q   <= clr_btn;
    end
  end

  // Rising-edge press detect. Qualified with rst_n so a button held during
  // reset cannot raise cnt_load while every output must read 0.
  assign ss_press  = rst_n & ss_btn  & ~ss_q;
  assign clr_press = rst_n & clr_btn & ~clr_q;

  assign zero = is_zero(digit1, digit0);

  // Next-state logic; clear wins over everything, and in RUN a zero count
  // wins over a start/stop press.
  always_comb begin
    state_d = state_q;
    if (clr_press) begin
      state_d = STATE_IDLE;
    end else begin
      unique case (state_q)
        STATE_IDLE:  if (ss_press && !zero) state_d = STATE_RUN;
        STATE_RUN: begin
          if (zero)          state_d = STATE_DONE;
          else if (ss_press) state_d = STATE_PAUSE;
        end
        STATE_PAUSE: if (ss_press) state_d = STATE_RUN;
        STATE_DONE:  state_d = STATE_DONE;
        default:     state_d = STATE_IDLE;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    running = DISABLED;
    paused  = DISABLED;
    alarm   = DISABLED;
    unique case (state_q)
      STATE_RUN:   running = ENABLED;
      STATE_PAUSE: paused  = ENABLED;
      STATE_DONE:  alarm   = ENABLED;
      default:     ;
    endcase
  end

  // The prescaler only advances in RUN and restarts on any state change, so
  // every entry into RUN sees a full TICK_DIV period before the first strobe
  // and a partial period left over from a pause is thrown away.
  assign tick_en  = (state_q == STATE_RUN);
  assign tick_clr = (state_q != STATE_RUN) || (state_d != state_q);

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .wrap_o (tick_wrap)
  );

  // tick_wrap already implies RUN. A press or a zero count in the same cycle
  // means the FSM is leaving RUN, so the strobe is withheld.
  assign cnt_en   = tick_wrap & ~zero & ~ss_press & ~clr_press;
  assign cnt_load = clr_press;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Testbench for countdown_ctrl with TICK_DIV=4. A BCD counter model is
// attached to the controller outputs, a mode/age model predicts every output
// on every cycle, and directed scenarios add hand-computed expectations.
module tb_countdown_ctrl;
  import countdown_ctrl_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ss_btn = 1'b0;
  logic clr_btn = 1'b0;
  logic [BCD_BIT_WIDTH-1:0] digit1, digit0;
  logic cnt_en, cnt_load, running, paused, alarm;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(.TICK_DIV(DIV), .TICK_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_btn   (ss_btn),
    .clr_btn  (clr_btn),
    .digit1   (digit1),
    .digit0   (digit0),
    .cnt_en   (cnt_en),
    .cnt_load (cnt_load),
    .running  (running),
    .paused   (paused),
    .alarm    (alarm)
  );

  // Attached 30 s BCD down-counter (environment, not the reference model).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit1 <= 4'd3;
      digit0 <= 4'd0;
    end else if (cnt_load) begin
      digit1 <= 4'd3;
      digit0 <= 4'd0;
    end else if (cnt_en) begin
      if (digit0 == 4'd0) begin
        digit0 <= 4'd9;
        digit1 <= digit1 - 4'd1;
      end else begin
        digit0 <= digit0 - 4'd1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_val();
    return int'(digit1) * 10 + int'(digit0);
  endfunction

  // Reference model: a mode plus the number of cycles spent in RUN since
  // the last entry. A strobe is due on every cycle whose age is DIV-1 mod DIV.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t mode = M_IDLE;
  int    age = 0;
  bit    ss_prev = 0, clr_prev = 0;

  always @(negedge clk) begin : model
    bit ssp, clrp, z, exp_en;
    if (!rst_n) begin
      mode = M_IDLE; age = 0; ss_prev = 0; clr_prev = 0;
      check("rst_outputs", {cnt_en, cnt_load, running, paused, alarm}, 0);
    end else begin
      ssp  = ss_btn && !ss_prev;
      clrp = clr_btn && !clr_prev;
      z    = (count_val() == 0);
      exp_en = (mode == M_RUN) && ((age % DIV) == DIV - 1) && !z && !ssp && !clrp;
      check("model_cnt_en",   cnt_en,   exp_en);
      check("model_cnt_load", cnt_load, clrp);
      check("model_running",  running,  mode == M_RUN);
      check("model_paused",   paused,   mode == M_PAUSE);
      check("model_alarm",    alarm,    mode == M_DONE);
      if (clrp) mode = M_IDLE;
      else begin
        case (mode)
          M_IDLE:  if (ssp && !z) begin mode = M_RUN; age = 0; end
          M_RUN:   if (z) mode = M_DONE;
                   else if (ssp) mode = M_PAUSE;
                   else age++;
          M_PAUSE: if (ssp) begin mode = M_RUN; age = 0; end
          default: ;
        endcase
      end
      ss_prev  = ss_btn;
      clr_prev = clr_btn;
    end
  end

  // Inputs change 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    ss_btn = 1'b1; tick(1); ss_btn = 1'b0;
  endtask

  // Cycles from now until cnt_en is seen (bounded).
  task automatic cycles_to_en(output int n);
    n = 0;
    #1;
    while (!cnt_en && n < 50) begin tick(1); #1; n++; end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, cnt;
    #1 rst_n = 1'b0;
    tick(2);
    check("reset_running", running, 0);
    check("reset_digits", count_val(), 30);
    rst_n = 1'b1;
    tick(2);

    // 1: start from 30; strobes every DIV cycles, first in the DIV-th RUN cycle.
    pulse_ss(); #1;
    check("t1_running", running, 1);
    cycles_to_en(n);
    check("t1_first_gap", n, DIV - 1);
    tick(1);
    check("t1_digits_29", count_val(), 29);
    cycles_to_en(n);
    check("t1_period", n, DIV - 1);
    tick(1);
    check("t1_digits_28", count_val(), 28);

    // 2: pause with prescaler at 2, resume, full period before next strobe.
    tick(2);
    pulse_ss(); #1;
    check("t2_paused", paused, 1);
    check("t2_not_running", running, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(1); if (cnt_en) cnt++; end
    check("t2_no_strobe_paused", cnt, 0);
    check("t2_digits_hold", count_val(), 28);
    pulse_ss(); #1;
    check("t2_resumed", running, 1);
    cycles_to_en(n);
    check("t2_resume_gap", n, DIV - 1);
    tick(1);
    check("t2_digits_27", count_val(), 27);

    // 3: run down to 00, alarm, DONE ignores ss, clr reloads.
    n = 0;
    while (count_val() != 1 && n < 300) begin tick(1); n++; end
    check("t3_reach_01", count_val(), 1);
    cycles_to_en(n);
    check("t3_last_gap", n, DIV - 1);
    tick(1);
    check("t3_digits_00", count_val(), 0);
    check("t3_alarm_not_yet", alarm, 0);
    check("t3_no_extra_strobe", cnt_en, 0);
    tick(1);
    check("t3_alarm", alarm, 1);
    check("t3_running_off", running, 0);
    pulse_ss(); tick(1); pulse_ss(); tick(1);
    check("t3_alarm_holds", alarm, 1);
    check("t3_digits_hold", count_val(), 0);
    cnt = 0;
    clr_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin #1; if (cnt_load) cnt++; tick(1); end
    clr_btn = 1'b0;
    check("t3_one_load", cnt, 1);
    check("t3_idle_alarm", alarm, 0);
    check("t3_digits_30", count_val(), 30);

    // 4: ss and clr together in RUN -> IDLE with one load, never paused.
    tick(1);
    pulse_ss();
    tick(5);
    ss_btn = 1'b1; clr_btn = 1'b1; #1;
    check("t4_load", cnt_load, 1);
    tick(1);
    ss_btn = 1'b0; clr_btn = 1'b0; #1;
    check("t4_load_once", cnt_load, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin if (paused || running) cnt++; tick(1); end
    check("t4_idle_not_paused", cnt, 0);
    check("t4_digits_30", count_val(), 30);

    // 5: ss held 10 cycles from IDLE -> exactly one entry into RUN.
    ss_btn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(1); if (running) cnt++; end
    ss_btn = 1'b0;
    check("t5_run_cycles", cnt, 10);

    // 6: async reset mid-RUN.
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_zero", {cnt_en, cnt_load, running, paused, alarm}, 0);
    tick(2);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (cnt_en || running) cnt++; end
    check("t6_idle_after_reset", cnt, 0);
    check("t6_digits_30", count_val(), 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
